gcd_engine: RTL

- Parametrised, self-sequencing GCD unit.
- Accepts an operand pair over a valid/ready handshake and runs subtractive Euclid on internal A/B registers, one compare-and-subtract per cycle.
- Presents the result, plus an iteration count, over a second valid/ready handshake.
- Successor to the fixed 16-bit datapath-plus-external-controller arrangement: FSM and datapath live in one block, operand width is generic, and zero operands are handled.

---
 rtl/gcd_pkg.sv | 13 +
 rtl/gcd_step.sv | 21 ++
 rtl/gcd_engine.sv | 97 +++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// Shared types and default sizes for the subtractive-Euclid GCD engine.
package gcd_pkg;

  localparam int GCD_WIDTH = 16;
  localparam int GCD_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gcd_state_e;

endpackage

// File: rtl/gcd_step.sv
// One combinational compare-and-subtract step of subtractive Euclid.
module gcd_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] a_next,
  output logic [WIDTH-1:0] b_next,
  output logic             eq,
  output logic             gt
);

  // Only the larger operand is reduced, so the subtraction never borrows.
  always_comb begin
    eq     = (a == b);
    gt     = (a > b);
    a_next = gt ? (a - b) : a;
    b_next = (!gt && !eq) ? (b - a) : b;
  end

endmodule

// File: rtl/gcd_engine.sv
// Self-sequencing GCD unit: operand handshake in, subtractive Euclid, result handshake out.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH,
  parameter int CNT_W = GCD_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd_out,
  output logic [CNT_W-1:0] iter_count,
  output logic             busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never drops before that edge, and ready is only high in
  // IDLE (input side) / valid only high in DONE (output side).

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  gcd_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, gcd_q;
  logic [WIDTH-1:0] a_next, b_next;
  logic [CNT_W-1:0] cnt_q;
  logic             eq, gt;
  logic             accept, zero_op;

  gcd_step #(.WIDTH(WIDTH)) u_step (
    .a      (a_q),
    .b      (b_q),
    .a_next (a_next),
    .b_next (b_next),
    .eq     (eq),
    .gt     (gt)
  );

  assign in_ready   = (state_q == IDLE) & ~rst;
  assign accept     = in_valid & in_ready;
  assign zero_op    = (a_in == '0) | (b_in == '0);
  assign busy       = (state_q == CALC);
  assign out_valid  = (state_q == DONE);
  assign gcd_out    = gcd_q;
  assign iter_count = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = zero_op ? DONE : CALC;
      CALC:    if (eq) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      gcd_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q   <= a_in;
            b_q   <= b_in;
            cnt_q <= '0;
            // A zero operand short-circuits: the other operand is the answer.
            if (zero_op) gcd_q <= a_in | b_in;
          end
        end
        CALC: begin
          if (eq) begin
            gcd_q <= a_q;
          end else begin
            if (gt) a_q <= a_next;
            else    b_q <= b_next;
            if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
